// File: rtl/secure_word_bank.sv
// secure_word_bank: lockable data-word registers with registered read-back and a
// one-word-per-cycle zeroization sweep, triggered by the cipher core or by software.
module secure_word_bank #(
  parameter int NUM_WORDS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_LSB  = 3,
  parameter int IDX_W     = 6,
  parameter int ADDR_BASE = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_WORDS-1:0]        reglk_ctrl_i,
  input  logic                        en_i,
  input  logic                        we_i,
  input  logic                        re_i,
  input  logic [31:0]                 address_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        rvalid_o,
  input  logic                        ct_valid_i,
  input  logic                        clr_req_i,
  output logic [NUM_WORDS*DATA_W-1:0] words_o,
  output logic [NUM_WORDS-1:0]        valid_mask_o,
  output logic                        full_o,
  output logic                        zeroize_busy_o,
  output logic                        zeroize_done_o,
  output logic                        write_err_o
);

  localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_ZEROIZE = 1'b1;

  logic [0:0]        r_state;
  logic [SEL_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_words [NUM_WORDS];
  logic [NUM_WORDS-1:0] r_mask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;

  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_idx_ext;
  logic [31:0]       w_rel;
  logic              w_in_range;
  logic [SEL_W-1:0]  w_sel;
  logic              w_locked;
  logic              w_wr;
  logic              w_rd;
  logic              w_trig;
  logic              w_last;
  logic              w_unused_addr;

  // Bus handshake: a request is a single cycle with en_i and a strobe high; there is
  // no back-pressure. A read answers with an rvalid_o pulse exactly one cycle later,
  // and a dropped write answers with a write_err_o pulse one cycle later.
  assign w_wr   = en_i & we_i;
  assign w_rd   = en_i & re_i;
  assign w_trig = ct_valid_i | clr_req_i;

  assign w_idx         = address_i[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign w_idx_ext     = 32'(w_idx);
  assign w_rel         = w_idx_ext - 32'(ADDR_BASE);
  assign w_in_range    = (w_idx_ext >= 32'(ADDR_BASE)) &&
                         (w_idx_ext <  32'(ADDR_BASE + NUM_WORDS));
  // Lowest index maps to the highest word.
  assign w_sel         = SEL_W'(32'(NUM_WORDS - 1) - w_rel);
  assign w_locked      = reglk_ctrl_i[w_sel];
  assign w_last        = (r_cnt == SEL_W'(NUM_WORDS - 1));
  assign w_unused_addr = ^address_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_words[k] <= '0;
      end
    end else begin
      r_rvalid <= w_rd;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd) begin
            r_rdata <= w_in_range ? r_words[w_sel] : '0;
          end
          if (w_trig) begin
            r_state <= ST_ZEROIZE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_err   <= w_wr;
          end else if (w_wr && w_in_range) begin
            if (w_locked) begin
              r_err <= 1'b1;
            end else begin
              r_words[w_sel] <= wdata_i;
              r_mask[w_sel]  <= 1'b1;
            end
          end
        end
        default: begin
          // Sweep ignores locks and further triggers; the bus sees zeros and errors.
          if (w_rd) begin
            r_rdata <= '0;
          end
          r_err          <= w_wr;
          r_words[r_cnt] <= '0;
          r_cnt          <= r_cnt + SEL_W'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
    assign words_o[k*DATA_W +: DATA_W] = r_words[k];
  end

  assign rdata_o        = r_rdata;
  assign rvalid_o       = r_rvalid;
  assign valid_mask_o   = r_mask;
  assign full_o         = &r_mask;
  assign zeroize_busy_o = (r_state == ST_ZEROIZE);
  assign zeroize_done_o = (r_state == ST_ZEROIZE) && w_last;
  assign write_err_o    = r_err;

endmodule

// File: tb/tb_secure_word_bank.sv
// Bench for secure_word_bank: directed scenarios plus a randomized run, all checked
// against a word-array / sweep-queue reference model.
module tb_secure_word_bank;

  localparam int NUM_WORDS = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_LSB  = 3;
  localparam int IDX_W     = 6;
  localparam int ADDR_BASE = 1;
  localparam int W         = NUM_WORDS * DATA_W;

  logic                 clk_i        = 1'b0;
  logic                 rst_i        = 1'b1;
  logic [NUM_WORDS-1:0] reglk_ctrl_i = '0;
  logic                 en_i         = 1'b0;
  logic                 we_i         = 1'b0;
  logic                 re_i         = 1'b0;
  logic [31:0]          address_i    = '0;
  logic [DATA_W-1:0]    wdata_i      = '0;
  logic                 ct_valid_i   = 1'b0;
  logic                 clr_req_i    = 1'b0;
  logic [DATA_W-1:0]    rdata_o;
  logic                 rvalid_o;
  logic [W-1:0]         words_o;
  logic [NUM_WORDS-1:0] valid_mask_o;
  logic                 full_o;
  logic                 zeroize_busy_o;
  logic                 zeroize_done_o;
  logic                 write_err_o;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0]    m_words [NUM_WORDS];
  logic [NUM_WORDS-1:0] m_mask;
  logic                 m_rvalid;
  logic                 m_err;
  int                   sweep_q[$];
  logic [DATA_W-1:0]    exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  secure_word_bank #(
    .NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .ADDR_LSB(ADDR_LSB),
    .IDX_W(IDX_W), .ADDR_BASE(ADDR_BASE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reglk_ctrl_i(reglk_ctrl_i),
    .en_i(en_i), .we_i(we_i), .re_i(re_i), .address_i(address_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .ct_valid_i(ct_valid_i), .clr_req_i(clr_req_i), .words_o(words_o),
    .valid_mask_o(valid_mask_o), .full_o(full_o),
    .zeroize_busy_o(zeroize_busy_o), .zeroize_done_o(zeroize_done_o),
    .write_err_o(write_err_o)
  );

  // ---------------- reference model ----------------
  function automatic int word_of(logic [31:0] addr);
    int idx;
    idx = int'(addr[ADDR_LSB +: IDX_W]);
    if (idx >= ADDR_BASE && idx < ADDR_BASE + NUM_WORDS) return NUM_WORDS - 1 - (idx - ADDR_BASE);
    return -1;
  endfunction

  function automatic logic [31:0] addr_of(int idx);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_LSB +: IDX_W] = IDX_W'(idx);
    return a;
  endfunction

  function automatic logic [W-1:0] m_pack();
    logic [W-1:0] v;
    for (int k = 0; k < NUM_WORDS; k++) v[k*DATA_W +: DATA_W] = m_words[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_WORDS; k++) m_words[k] = '0;
    m_mask = '0;
    m_rvalid = 1'b0;
    m_err = 1'b0;
    sweep_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_write(int idx, logic [DATA_W-1:0] d);
    en_i = 1'b1; we_i = 1'b1; address_i = addr_of(idx); wdata_i = d;
  endtask

  task automatic set_read(int idx);
    en_i = 1'b1; re_i = 1'b1; address_i = addr_of(idx);
  endtask

  // Advance the model with the inputs currently applied, clock once, drop strobes.
  task automatic cycle();
    int  w;
    bit  busy;
    w = word_of(address_i);
    busy = (sweep_q.size() > 0);
    m_err = 1'b0;
    m_rvalid = 1'b0;
    if (en_i && re_i) begin
      m_rvalid = 1'b1;
      exp_q.push_back((busy || w < 0) ? '0 : m_words[w]);
    end
    if (busy) begin
      if (en_i && we_i) m_err = 1'b1;
      m_words[sweep_q.pop_front()] = '0;
    end else if (ct_valid_i || clr_req_i) begin
      if (en_i && we_i) m_err = 1'b1;
      m_mask = '0;
      for (int k = 0; k < NUM_WORDS; k++) sweep_q.push_back(k);
    end else if (en_i && we_i && w >= 0) begin
      if (reglk_ctrl_i[w]) m_err = 1'b1;
      else begin
        m_words[w] = wdata_i;
        m_mask[w] = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    en_i = 1'b0; we_i = 1'b0; re_i = 1'b0; ct_valid_i = 1'b0; clr_req_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_WORDS; i++) begin
      set_write(ADDR_BASE + i, $urandom);
      cycle();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (words_o !== '0) begin errors++; $display("FAIL reset_words: got %h expected 0", words_o); end
    checks++; if (valid_mask_o !== '0) begin errors++; $display("FAIL reset_mask: got %h expected 0", valid_mask_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_o); end
    checks++; if (zeroize_busy_o !== 1'b0 || zeroize_done_o !== 1'b0) begin errors++; $display("FAIL reset_zeroize: got busy %b done %b expected 0 0", zeroize_busy_o, zeroize_done_o); end
    checks++; if (rvalid_o !== 1'b0 || write_err_o !== 1'b0 || rdata_o !== '0) begin errors++; $display("FAIL reset_bus: got rvalid %b err %b rdata %h expected 0 0 0", rvalid_o, write_err_o, rdata_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < NUM_WORDS; i++) begin
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fill_full_early: got %b expected 0 after %0d writes", full_o, i); end
      set_write(ADDR_BASE + i, 32'hA5A5_0001 + DATA_W'(i));
      cycle();
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      checks++;
      if (words_o[k*DATA_W +: DATA_W] !== 32'hA5A5_0001 + DATA_W'(NUM_WORDS - 1 - k)) begin
        errors++; $display("FAIL fill_word%0d: got %h expected %h", k, words_o[k*DATA_W +: DATA_W], 32'hA5A5_0001 + DATA_W'(NUM_WORDS - 1 - k));
      end
    end
    checks++; if (valid_mask_o !== 4'hF) begin errors++; $display("FAIL fill_mask: got %h expected f", valid_mask_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full_o); end
  endtask

  task automatic test_lock();
    logic [DATA_W-1:0] d;
    reglk_ctrl_i = 4'b0100;
    set_write(2, 32'hDEAD_BEEF);
    cycle();
    checks++; if (write_err_o !== 1'b1) begin errors++; $display("FAIL lock_err: got %b expected 1", write_err_o); end
    checks++; if (words_o[2*DATA_W +: DATA_W] !== 32'hA5A5_0002) begin errors++; $display("FAIL lock_word2: got %h expected a5a50002", words_o[2*DATA_W +: DATA_W]); end
    set_read(2);
    cycle();
    checks++; if (write_err_o !== 1'b0) begin errors++; $display("FAIL lock_err_pulse: got %b expected 0", write_err_o); end
    checks++; if (rvalid_o !== 1'b1 || rdata_o !== exp_q.pop_front()) begin errors++; $display("FAIL lock_read: got rvalid %b rdata %h expected 1 a5a50002", rvalid_o, rdata_o); end
    // Read and write of the same unlocked word in one cycle: read sees old data.
    d = $urandom;
    set_write(ADDR_BASE, d);
    re_i = 1'b1;
    cycle();
    checks++; if (rvalid_o !== 1'b1 || rdata_o !== exp_q.pop_front()) begin errors++; $display("FAIL rw_same_old: got rvalid %b rdata %h expected 1 a5a50001", rvalid_o, rdata_o); end
    checks++; if (words_o[(NUM_WORDS-1)*DATA_W +: DATA_W] !== d || write_err_o !== 1'b0) begin errors++; $display("FAIL rw_same_new: got %h err %b expected %h err 0", words_o[(NUM_WORDS-1)*DATA_W +: DATA_W], write_err_o, d); end
    reglk_ctrl_i = '0;
  endtask

  task automatic test_zeroize();
    fill_random();
    reglk_ctrl_i = '1;
    ct_valid_i = 1'b1;
    cycle();
    checks++; if (zeroize_busy_o !== 1'b1 || zeroize_done_o !== 1'b0) begin errors++; $display("FAIL zero_entry: got busy %b done %b expected 1 0", zeroize_busy_o, zeroize_done_o); end
    checks++; if (valid_mask_o !== '0 || full_o !== 1'b0) begin errors++; $display("FAIL zero_mask: got %h full %b expected 0 0", valid_mask_o, full_o); end
    checks++; if (words_o !== m_pack()) begin errors++; $display("FAIL zero_entry_words: got %h expected %h", words_o, m_pack()); end
    for (int k = 0; k < NUM_WORDS; k++) begin
      checks++; if (zeroize_busy_o !== 1'b1 || zeroize_done_o !== (k == NUM_WORDS - 1)) begin errors++; $display("FAIL zero_cycle%0d: got busy %b done %b expected 1 %b", k, zeroize_busy_o, zeroize_done_o, k == NUM_WORDS - 1); end
      if (k == 0) set_write(ADDR_BASE, $urandom);
      if (k == 1) set_read(ADDR_BASE + NUM_WORDS - 1);
      if (k == 2) clr_req_i = 1'b1;
      cycle();
      checks++; if (words_o[k*DATA_W +: DATA_W] !== '0 || words_o !== m_pack()) begin errors++; $display("FAIL zero_order%0d: got %h expected %h", k, words_o, m_pack()); end
      if (k == 0) begin
        checks++; if (write_err_o !== 1'b1) begin errors++; $display("FAIL zero_write_err: got %b expected 1", write_err_o); end
      end
      if (k == 1) begin
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== '0 || exp_q.pop_front() !== '0) begin errors++; $display("FAIL zero_read: got rvalid %b rdata %h expected 1 0", rvalid_o, rdata_o); end
      end
    end
    checks++; if (zeroize_busy_o !== 1'b0 || zeroize_done_o !== 1'b0 || words_o !== '0) begin errors++; $display("FAIL zero_end: got busy %b done %b words %h expected 0 0 0", zeroize_busy_o, zeroize_done_o, words_o); end
    reglk_ctrl_i = '0;
  endtask

  task automatic test_entry_cycle();
    logic [DATA_W-1:0] d;
    fill_random();
    d = m_words[NUM_WORDS-1];
    set_write(ADDR_BASE, ~d);
    clr_req_i = 1'b1;
    cycle();
    checks++; if (write_err_o !== 1'b1 || words_o[(NUM_WORDS-1)*DATA_W +: DATA_W] !== d) begin errors++; $display("FAIL entry_write: got err %b word %h expected 1 %h", write_err_o, words_o[(NUM_WORDS-1)*DATA_W +: DATA_W], d); end
    repeat (NUM_WORDS) cycle();
    fill_random();
    set_read(ADDR_BASE);
    ct_valid_i = 1'b1;
    cycle();
    checks++; if (rvalid_o !== 1'b1 || rdata_o !== exp_q.pop_front()) begin errors++; $display("FAIL entry_read: got rvalid %b rdata %h expected 1 %h", rvalid_o, rdata_o, m_words[NUM_WORDS-1]); end
    repeat (NUM_WORDS) cycle();
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    fill_random();
    clr_req_i = 1'b1;
    cycle();
    repeat (2) cycle();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++; if (words_o !== '0 || zeroize_busy_o !== 1'b0 || valid_mask_o !== '0) begin errors++; $display("FAIL async_reset: got words %h busy %b mask %h expected 0 0 0", words_o, zeroize_busy_o, valid_mask_o); end
    #1;
    rst_i = 1'b0;
    d = $urandom;
    set_write(ADDR_BASE, d);
    cycle();
    checks++; if (words_o !== m_pack() || valid_mask_o !== m_mask || write_err_o !== 1'b0) begin errors++; $display("FAIL post_reset_write: got %h mask %h err %b expected %h %h 0", words_o, valid_mask_o, write_err_o, m_pack(), m_mask); end
  endtask

  task automatic test_out_of_range();
    int bad [3];
    fill_random();
    bad[0] = 0; bad[1] = ADDR_BASE + NUM_WORDS; bad[2] = (1 << IDX_W) - 1;
    for (int i = 0; i < 3; i++) begin
      set_write(bad[i], $urandom);
      cycle();
      checks++; if (words_o !== m_pack() || valid_mask_o !== m_mask || write_err_o !== 1'b0) begin errors++; $display("FAIL oor_write_idx%0d: got %h mask %h err %b expected %h %h 0", bad[i], words_o, valid_mask_o, write_err_o, m_pack(), m_mask); end
      set_read(bad[i]);
      cycle();
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== '0 || exp_q.pop_front() !== '0) begin errors++; $display("FAIL oor_read_idx%0d: got rvalid %b rdata %h expected 1 0", bad[i], rvalid_o, rdata_o); end
    end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      reglk_ctrl_i = ($urandom_range(0, 3) == 0) ? NUM_WORDS'($urandom) : '0;
      en_i = ($urandom_range(0, 7) != 0);
      we_i = 1'($urandom_range(0, 1));
      re_i = 1'($urandom_range(0, 1));
      address_i = addr_of($urandom_range(0, ADDR_BASE + NUM_WORDS));
      wdata_i = $urandom;
      ct_valid_i = ($urandom_range(0, 24) == 0);
      clr_req_i = ($urandom_range(0, 24) == 0);
      cycle();
      checks++; if (words_o !== m_pack()) begin errors++; $display("FAIL rand_words@%0d: got %h expected %h", n, words_o, m_pack()); end
      checks++; if (valid_mask_o !== m_mask || full_o !== &m_mask) begin errors++; $display("FAIL rand_mask@%0d: got %h full %b expected %h %b", n, valid_mask_o, full_o, m_mask, &m_mask); end
      checks++; if (zeroize_busy_o !== (sweep_q.size() > 0) || zeroize_done_o !== (sweep_q.size() == 1)) begin errors++; $display("FAIL rand_zeroize@%0d: got busy %b done %b expected %b %b", n, zeroize_busy_o, zeroize_done_o, sweep_q.size() > 0, sweep_q.size() == 1); end
      checks++; if (write_err_o !== m_err || rvalid_o !== m_rvalid) begin errors++; $display("FAIL rand_bus@%0d: got err %b rvalid %b expected %b %b", n, write_err_o, rvalid_o, m_err, m_rvalid); end
      if (m_rvalid) begin
        checks++; if (rdata_o !== exp_q[0]) begin errors++; $display("FAIL rand_rdata@%0d: got %h expected %h", n, rdata_o, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_fill();
    test_lock();
    test_zeroize();
    test_entry_cycle();
    test_async_reset();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secure_word_bank.md
Name: secure_word_bank

Overview:
- Parametrised successor to the crypto-engine plaintext/ciphertext word registers.
- Holds NUM_WORDS data words written over the peripheral bus, with a per-word write lock and a registered read-back path.
- On engine completion or software request, runs a sequential zeroization sweep that clears one word per cycle and blocks access until the sweep finishes.
- Sits between the bus slave decoder and the cipher core, which reads words_o in parallel.

Parameters:
- NUM_WORDS, 4, number of DATA_W-bit words held (1..32).
- DATA_W, 32, word width in bits.
- ADDR_LSB, 3, lowest address bit of the word index field.
- IDX_W, 6, width of the word index field address_i[ADDR_LSB+IDX_W-1:ADDR_LSB].
- ADDR_BASE, 1, index value that maps to the highest word (word NUM_WORDS-1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- reglk_ctrl_i  in  NUM_WORDS  bit k=1 write-locks word k.
- en_i  in  1  bus access enable.
- we_i  in  1  write strobe (qualified by en_i).
- re_i  in  1  read strobe (qualified by en_i).
- address_i  in  32  bus address.
- wdata_i  in  DATA_W  write data.
- rdata_o  out  DATA_W  registered read data.
- rvalid_o  out  1  one-cycle pulse, rdata_o valid.
- ct_valid_i  in  1  cipher core done; triggers zeroize.
- clr_req_i  in  1  software clear request; triggers zeroize.
- words_o  out  NUM_WORDS*DATA_W  word k at bits [k*DATA_W +: DATA_W].
- valid_mask_o  out  NUM_WORDS  bit k set once word k has been written since the last clear.
- full_o  out  1  all valid_mask_o bits set.
- zeroize_busy_o  out  1  sweep in progress.
- zeroize_done_o  out  1  one-cycle pulse on the final sweep cycle.
- write_err_o  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (asynchronous, immediate): all words, valid_mask_o, rdata_o = 0; rvalid_o, write_err_o, zeroize_* = 0; FSM = IDLE. Reset during a sweep aborts it; the bank is already fully zero.
- Index decode: idx = address_i field; rel = idx - ADDR_BASE.
  - Word select: ADDR_BASE <= idx < ADDR_BASE+NUM_WORDS selects word NUM_WORDS-1-rel (mirrored order).
  - Any other index is out of range.
- FSM states:
  - IDLE: accepts bus access.
  - ZEROIZE: sweep counter cnt runs 0..NUM_WORDS-1.
- IDLE write (en_i & we_i):
  - In range and not locked: word <= wdata_i and its valid_mask bit <= 1, effective next edge.
  - In range and locked: word and mask unchanged; write_err_o pulses the next cycle.
  - Out of range: silently ignored, no error.
- IDLE read (en_i & re_i): rdata_o and rvalid_o update at the next edge, so latency is 1. Out-of-range reads return 0. Lock does not block reads. Simultaneous re_i and we_i to the same word returns the old value.
- Zeroize entry: ct_valid_i | clr_req_i sampled high in IDLE moves to ZEROIZE.
  - In that same cycle, a bus write is dropped with write_err_o; a read completes normally.
  - cnt <= 0; valid_mask_o <= 0 immediately.
- ZEROIZE: each cycle word[cnt] <= 0 and cnt++.
  - zeroize_busy_o = 1 for exactly NUM_WORDS cycles.
  - zeroize_done_o pulses in the cycle that clears word NUM_WORDS-1; the next state is IDLE.
- ZEROIZE bus access:
  - Writes are dropped with write_err_o, whether or not the word is locked.
  - Reads return rdata_o = 0 with rvalid_o = 1.
  - Further ct_valid_i or clr_req_i is ignored and does not restart the sweep.
- Lock bits never block zeroization.
- full_o = &valid_mask_o, combinational from registers.
- words_o is driven directly from the storage registers, with no added latency.

Test Plan:
- Reset, then write 0xA5A5_0001..0004 to indices 1..4 with reglk_ctrl_i=0 -> words_o word3..word0 = 0x..01..0x..04; valid_mask_o=4'hF; full_o=1.
- reglk_ctrl_i=4'b0100, write 0xDEAD_BEEF to index 2 -> word2 unchanged; write_err_o pulses 1 cycle; read of index 2 returns the old value one cycle later with rvalid_o=1.
- Filled bank, pulse ct_valid_i -> zeroize_busy_o high 4 cycles; words clear in order 0,1,2,3 one per cycle; zeroize_done_o pulses on the 4th cycle; valid_mask_o=0 from the first cycle.
- During the sweep: write index 1 -> write_err_o, no change; read index 4 -> rdata_o=0 with rvalid_o; second clr_req_i -> sweep length still 4.
- Assert rst_i asynchronously mid-sweep (after 2 cycles) -> all words 0 without a clock edge; FSM IDLE; a write accepted on the first cycle after release.
- Out-of-range write to index 0 and index 5 -> no state change, no write_err_o; read returns 0.
